// File: rtl/tempsense_sar_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tempsense_sar_ctrl
//  Purpose  : Successive-approximation controller for a delay-line
//             temperature sensor. For each bit, MSB first, it precharges
//             the core, releases it, drives a trial DAC code for N_MEAS
//             cycles and then keeps or drops the trial bit depending on
//             the delay-line verdict (i_tempdelay = 0 means the trial
//             code passes).
//  Ports    :
//    clk            in   single clock, rising edge
//    reset          in   synchronous, active-high reset
//    start          in   conversion request, honoured only in IDLE
//    auto_mode      in   restart a conversion straight after DONE
//    i_tempdelay    in   delay-line verdict, used only in EVALUATE
//    o_dac_data     out  [N_VDAC] DAC code to the core
//    o_dac_en       out  DAC enable to the core
//    o_precharge_n  out  active-low precharge to the core
//    result         out  [N_VDAC] last completed conversion value
//    busy           out  high in every state except IDLE
//    done           out  one-cycle pulse in DONE
//  Revision : 1.0  initial release
// ============================================================================
module tempsense_sar_ctrl #(
  parameter int N_VDAC = 6,
  parameter int N_MEAS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              auto_mode,
  input  logic              i_tempdelay,
  output logic [N_VDAC-1:0] o_dac_data,
  output logic              o_dac_en,
  output logic              o_precharge_n,
  output logic [N_VDAC-1:0] result,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
  localparam int CNT_W = 4;
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(N_VDAC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_MEAS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRECHARGE  = 3'd1,
    S_TRANSITION = 3'd2,
    S_MEASURE    = 3'd3,
    S_EVALUATE   = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    bit_idx, bit_idx_next;
  logic [N_VDAC-1:0]   trial, trial_next;
  logic [CNT_W-1:0]    meas_cnt, meas_cnt_next;
  logic [N_VDAC-1:0]   result_next;
  logic [N_VDAC-1:0]   bit_mask;
  logic [N_VDAC-1:0]   trial_eval;

  // One-hot mask of the bit currently under trial.
  assign bit_mask = {{(N_VDAC-1){1'b0}}, 1'b1} << bit_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_idx  <= '0;
      trial    <= '0;
      meas_cnt <= '0;
      result   <= '0;
    end else begin
      state    <= state_next;
      bit_idx  <= bit_idx_next;
      trial    <= trial_next;
      meas_cnt <= meas_cnt_next;
      result   <= result_next;
    end
  end

  // Next-state logic and output decode. Outputs depend only on registered
  // state; i_tempdelay feeds nothing but the trial/result next values.
  always_comb begin
    state_next    = state;
    bit_idx_next  = bit_idx;
    trial_next    = trial;
    meas_cnt_next = meas_cnt;
    result_next   = result;
    trial_eval    = i_tempdelay ? trial : (trial | bit_mask);
    o_dac_en      = 1'b0;
    o_dac_data    = '1;
    o_precharge_n = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next   = S_PRECHARGE;
          bit_idx_next = IDX_MSB;
          trial_next   = '0;
        end
      end

      S_PRECHARGE: begin
        o_dac_en   = 1'b1;
        state_next = S_TRANSITION;
      end

      S_TRANSITION: begin
        o_dac_en      = 1'b1;
        o_dac_data    = '0;
        o_precharge_n = 1'b1;
        meas_cnt_next = '0;
        state_next    = S_MEASURE;
      end

      S_MEASURE: begin
        o_dac_en      = 1'b1;
        o_precharge_n = 1'b1;
        o_dac_data    = trial | bit_mask;
        if (meas_cnt == CNT_LAST) begin
          state_next = S_EVALUATE;
        end else begin
          meas_cnt_next = meas_cnt + 1'b1;
        end
      end

      S_EVALUATE: begin
        o_dac_en      = 1'b1;
        o_precharge_n = 1'b1;
        o_dac_data    = trial | bit_mask;
        trial_next    = trial_eval;
        if (bit_idx == '0) begin
          // Last decision goes straight into result so it is valid in DONE.
          result_next = trial_eval;
          state_next  = S_DONE;
        end else begin
          bit_idx_next = bit_idx - 1'b1;
          state_next   = S_PRECHARGE;
        end
      end

      S_DONE: begin
        o_dac_en = 1'b1;
        done     = 1'b1;
        if (auto_mode) begin
          state_next   = S_PRECHARGE;
          bit_idx_next = IDX_MSB;
          trial_next   = '0;
        end else begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tempsense_sar_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tempsense_sar_ctrl
//  Purpose  : Self-checking bench for tempsense_sar_ctrl. A threshold core
//             model (code passes iff code <= thr) drives i_tempdelay; the
//             expected waveform is derived from the conversion schedule
//             and the binary-search outcome (result = thr, or 0 when the
//             core never passes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tempsense_sar_ctrl;

  localparam int N_VDAC = 6;
  localparam int N_MEAS = 2;
  localparam int PER    = N_MEAS + 3;
  localparam int LAT    = N_VDAC * PER + 1;
  localparam int ALL1   = (1 << N_VDAC) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              auto_mode;
  logic              i_tempdelay;
  logic [N_VDAC-1:0] o_dac_data;
  logic              o_dac_en;
  logic              o_precharge_n;
  logic [N_VDAC-1:0] result;
  logic              busy;
  logic              done;

  int thr;
  bit never;
  int held_res;
  int n_checks = 0;
  int n_pass   = 0;

  tempsense_sar_ctrl #(.N_VDAC(N_VDAC), .N_MEAS(N_MEAS)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .auto_mode     (auto_mode),
    .i_tempdelay   (i_tempdelay),
    .o_dac_data    (o_dac_data),
    .o_dac_en      (o_dac_en),
    .o_precharge_n (o_precharge_n),
    .result        (result),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Threshold core: 0 = pass.
  function automatic logic core_td();
    if (never) return 1'b1;
    return (int'(o_dac_data) > thr) ? 1'b1 : 1'b0;
  endfunction

  task automatic check_idle(input string tag, input int exp_res);
    check_eq({tag, " dac"},   int'(o_dac_data), ALL1);
    check_eq({tag, " en"},    int'(o_dac_en), 0);
    check_eq({tag, " pn"},    int'(o_precharge_n), 0);
    check_eq({tag, " busy"},  int'(busy), 0);
    check_eq({tag, " done"},  int'(done), 0);
    check_eq({tag, " res"},   int'(result), exp_res);
  endtask

  // Entered at #1 after the edge that moved the DUT into PRECHARGE (cycle 1).
  // Returns during DONE (cycle LAT), or during cycle abort_at with reset set.
  task automatic check_conv(input int exp_res, input int pulse_a, input int pulse_b,
                            input int abort_at, input string tg);
    int e_dac, e_en, e_pn, e_done, e_res, k, b, p, hi;
    bit is_eval;
    for (int c = 1; c <= LAT; c++) begin
      is_eval = 1'b0;
      if (c == LAT) begin
        e_dac = ALL1; e_en = 1; e_pn = 0; e_done = 1; e_res = exp_res;
      end else begin
        k  = c - 1;
        b  = N_VDAC - 1 - k / PER;
        p  = k % PER;
        hi = (exp_res >> (b + 1)) << (b + 1);
        e_done = 0; e_res = held_res; e_en = 1;
        if (p == 0) begin
          e_dac = ALL1; e_pn = 0;
        end else if (p == 1) begin
          e_dac = 0; e_pn = 1;
        end else begin
          e_dac = hi | (1 << b); e_pn = 1;
          is_eval = (p == PER - 1);
        end
      end
      check_eq($sformatf("%s c%0d dac", tg, c),  int'(o_dac_data), e_dac);
      check_eq($sformatf("%s c%0d en", tg, c),   int'(o_dac_en), e_en);
      check_eq($sformatf("%s c%0d pn", tg, c),   int'(o_precharge_n), e_pn);
      check_eq($sformatf("%s c%0d busy", tg, c), int'(busy), 1);
      check_eq($sformatf("%s c%0d done", tg, c), int'(done), e_done);
      check_eq($sformatf("%s c%0d res", tg, c),  int'(result), e_res);
      start       = (c == pulse_a) || (c == pulse_b);
      i_tempdelay = is_eval ? core_td() : 1'($urandom_range(0, 1));
      if (c == abort_at) begin
        reset = 1'b1;
        return;
      end
      if (c < LAT) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_conv(input int exp_res, input int pa, input int pb, input string tg);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_conv(exp_res, pa, pb, 0, tg);
    @(posedge clk); #1;
    start    = 1'b0;
    held_res = exp_res;
    for (int i = 0; i < 3; i++) begin
      check_idle($sformatf("%s post%0d", tg, i), held_res);
      i_tempdelay = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; auto_mode = 1'b0; i_tempdelay = 1'b0;
    thr = 37; never = 1'b0; held_res = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("in_reset", 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle("idle", 0);

    // Nominal threshold 37, includes per-phase output checks of the first bit.
    thr = 37;
    do_conv(37, 0, 0, "thr37");

    // Core always passes / never passes.
    thr = ALL1;
    do_conv(ALL1, 0, 0, "allpass");
    never = 1'b1;
    do_conv(0, 0, 0, "nopass");
    never = 1'b0;

    // start re-pulsed mid-conversion, and start during DONE.
    thr = 12;
    do_conv(12, 5, 20, "repulse");
    thr = int'($urandom_range(0, ALL1));
    do_conv(thr, LAT, 0, "start_in_done");

    // Reset during cycle 12 aborts without done or result update.
    thr = 37;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_conv(37, 0, 0, 12, "abort");
    @(posedge clk); #1;
    reset    = 1'b0;
    held_res = 0;
    check_idle("abort_next", 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_idle($sformatf("abort_quiet%0d", i), 0);
    end
    do_conv(37, 0, 0, "after_abort");

    // Auto mode: back-to-back conversions, threshold changes after first done.
    auto_mode = 1'b1;
    thr = 37;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_conv(37, 0, 0, 0, "auto1");
    held_res = 37;
    thr = 20;
    @(posedge clk); #1;
    auto_mode = 1'b0;
    check_conv(20, 0, 0, 0, "auto2");
    @(posedge clk); #1;
    held_res = 20;
    check_idle("auto_end", 20);

    // Randomized thresholds.
    for (int n = 0; n < 8; n++) begin
      never = ($urandom_range(0, 7) == 0);
      thr   = int'($urandom_range(0, ALL1));
      do_conv(never ? 0 : thr, 0, 0, $sformatf("rnd%0d", n));
    end
    never = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
